// File: rtl/matrix_mul.sv
// Sequential 3x3 unsigned matrix multiplier, C = A x B, 8-bit operands, 16-bit (mod 2^16) results.
// Latency: start sampled at edge 0, one element per edge on edges 1..9, done pulses after edge 9.
// No backpressure: start is only taken when idle (or on the done cycle), otherwise dropped, never queued.
module matrix_mul (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [71:0]  matrix_a,
    input  logic [71:0]  matrix_b,
    output logic [143:0] result,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;

    // latched operands and element counter
    logic [71:0]    a_q;
    logic [71:0]    b_q;
    logic [3:0]     k_q;

    // elements 0..7 are parked here; element 8 goes straight into result
    logic [15:0]    elem_q [0:7];

    logic [143:0]   result_q, result_d;
    logic           done_q;

    // control decoded from state
    logic           latch_op;
    logic           calc_en;
    logic           last_elem;
    logic           finish;

    // datapath intermediates
    logic [7:0]     a_el [0:8];
    logic [7:0]     b_el [0:8];
    logic [3:0]     row_base;
    logic [3:0]     col;
    logic [15:0]    prod;
    logic [15:0]    elem_new;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; the DONE cycle doubles as an idle cycle so a held start
    // re-issues every 10 cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (k_q == 4'd8) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? CALC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // control outputs decoded from the current state
    always_comb begin
        latch_op  = 1'b0;
        calc_en   = 1'b0;
        last_elem = 1'b0;
        case (state_q)
            IDLE:    latch_op = start;
            CALC: begin
                calc_en   = 1'b1;
                last_elem = (k_q == 4'd8);
            end
            DONE:    latch_op = start;
            default: latch_op = 1'b0;
        endcase
        finish = calc_en & last_elem;
    end

    // one dot product per cycle: row of A selected by k, column of B selected by k
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            a_el[i] = a_q[8*(8-i) +: 8];
            b_el[i] = b_q[8*(8-i) +: 8];
        end
        if (k_q >= 4'd6) begin
            row_base = 4'd6;
        end else if (k_q >= 4'd3) begin
            row_base = 4'd3;
        end else begin
            row_base = 4'd0;
        end
        col      = k_q - row_base;
        prod     = '0;
        elem_new = '0;
        // carries above bit 15 are dropped: the element is the sum modulo 2^16
        for (int j = 0; j < 3; j++) begin
            prod     = {8'd0, a_el[row_base + 4'(j)]} * {8'd0, b_el[4'(3*j) + col]};
            elem_new = elem_new + prod;
        end
    end

    // result is replaced in a single step when the last element is ready
    always_comb begin
        result_d = result_q;
        if (finish) begin
            for (int i = 0; i < 8; i++) begin
                result_d[16*(8-i) +: 16] = elem_q[i];
            end
            result_d[15:0] = elem_new;
        end
    end

    // operand capture, element buffer, result and done registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            if (latch_op) begin
                a_q <= matrix_a;
                b_q <= matrix_b;
                k_q <= '0;
            end else if (calc_en) begin
                if (!last_elem) begin
                    elem_q[k_q[2:0]] <= elem_new;
                end
                k_q <= k_q + 4'd1;
            end
            result_q <= result_d;
            done_q   <= finish;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_matrix_mul.sv
// Directed self-checking bench for matrix_mul.
// Drives inputs on the falling edge, samples outputs 1ns after the rising edge.
// Expected products are hand-computed constants.
module tb_matrix_mul;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [71:0]  ma;
    logic [71:0]  mb;
    logic [143:0] res;
    logic         dn;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matrix_mul dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .matrix_a (ma),
        .matrix_b (mb),
        .result   (res),
        .done     (dn)
    );

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pk8(input int unsigned e [0:8]);
        logic [71:0] r;
        int unsigned v;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            v = e[i];
            r[8*(8-i) +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [143:0] pk16(input int unsigned e [0:8]);
        logic [143:0] r;
        int unsigned v;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            v = e[i];
            r[16*(8-i) +: 16] = v[15:0];
        end
        return r;
    endfunction

    // count edges until done (bounded); n = edges waited, 99 if expired
    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (dn) return;
        end
        n = 99;
    endtask

    // one complete operation with latency, value and pulse-width checks
    task automatic do_op(input logic [71:0] a, input logic [71:0] b,
                         input logic [143:0] exp, input string tag);
        int n;
        @(negedge clk);
        ma = a; mb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ma = ~a; mb = ~b;           // operands must already be latched
        wait_done(n);
        check({tag, " latency"}, 144'(n), 144'(9));
        check({tag, " result"}, res, exp);
        @(posedge clk); #1;
        check({tag, " done width"}, 144'(dn), 144'(0));
        check({tag, " hold"}, res, exp);
    endtask

    logic [71:0]  a1, b1, aid, a2id, b19, a3, b3, aff;
    logic [143:0] r1, rid, r2id, r3, rff;

    initial begin
        int n;
        int pulses;
        int pe [0:2];
        int bad_val;
        logic [143:0] last;

        a1   = pk8('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        b1   = pk8('{9, 8, 7, 6, 5, 4, 3, 2, 1});
        r1   = pk16('{30, 24, 18, 84, 69, 54, 138, 114, 90});
        aid  = pk8('{1, 0, 0, 0, 1, 0, 0, 0, 1});
        a2id = pk8('{2, 0, 0, 0, 2, 0, 0, 0, 2});
        b19  = pk8('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        rid  = pk16('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        r2id = pk16('{2, 4, 6, 8, 10, 12, 14, 16, 18});
        a3   = pk8('{1, 2, 3, 0, 1, 4, 0, 0, 1});
        b3   = pk8('{1, 0, 0, 2, 1, 0, 3, 4, 1});
        r3   = pk16('{14, 14, 3, 14, 17, 4, 3, 4, 1});
        aff  = {72{1'b1}};
        rff  = {9{16'd64003}};

        reset = 1'b0; start = 1'b0; ma = '0; mb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", res, '0);
        check("reset done", 144'(dn), 144'(0));
        @(negedge clk);
        reset = 1'b1;

        do_op(a1, b1, r1, "basic");
        do_op(aid, b19, rid, "identity");
        do_op(a2id, b19, r2id, "scaled id");
        do_op(a3, b3, r3, "triangular");
        do_op(aff, aff, rff, "overflow");

        // second start during CALC must be ignored
        @(negedge clk);
        ma = a1; mb = b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        ma = a2id; mb = b19; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ignored start latency", 144'(n), 144'(5));
        check("ignored start result", res, r1);
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (dn) pulses++;
        end
        check("ignored start no 2nd done", 144'(pulses), 144'(0));

        // start held high: done every 10 cycles, each op takes its own inputs
        @(negedge clk);
        ma = aid; mb = b19; start = 1'b1;
        pulses = 0; bad_val = 0; last = res;
        pe[0] = 0; pe[1] = 0; pe[2] = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (dn) begin
                if (pulses < 3) pe[pulses] = e;
                if (pulses == 0) begin
                    check("held start 1st result", res, rid);
                    ma = a2id;
                end else begin
                    check("held start later result", res, r2id);
                end
                pulses++;
                last = res;
            end else if (res !== last) begin
                bad_val++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held start pulses", 144'(pulses), 144'(3));
        check("held start first", 144'(pe[0]), 144'(9));
        check("held start interval 1", 144'(pe[1] - pe[0]), 144'(10));
        check("held start interval 2", 144'(pe[2] - pe[1]), 144'(10));
        check("held start stability", 144'(bad_val), 144'(0));
        repeat (2) @(posedge clk);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        ma = a1; mb = b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset result", res, '0);
        check("async reset done", 144'(dn), 144'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (dn) pulses++;
        end
        check("after reset no done", 144'(pulses), 144'(0));
        check("after reset result held 0", res, '0);
        do_op(a3, b3, r3, "post reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog expired");
    end

endmodule
